aes_round_sequencer: RTL

// - Upstream control and key stage for the AES-128 rounds datapath.
// - Accepts one plaintext/key pair per transaction over a valid/ready handshake.
// - Expands round keys on the fly, one per cycle, and drives the datapath enables,
//   mux selects and round_key.
// - Captures the datapath cipher_text after the final round and presents it downstream

---
 rtl/aes_round_sequencer_if.sv | 45 ++++
 rtl/aes_round_sequencer.sv | 133 +++++++++++++
 2 files changed

// File: rtl/aes_round_sequencer_if.sv
// Bundles the plaintext/key intake, the datapath control and the ciphertext output of aes_round_sequencer.
// The in_key_reuse signal exists only when AES_KEY_REUSE_EN is defined.
interface aes_round_sequencer_if #(
  parameter int DATA_WIDTH = 128,
  parameter int KEY_WIDTH  = 128
);
  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] in_plaintext;
  logic [KEY_WIDTH-1:0]  in_key;
`ifdef AES_KEY_REUSE_EN
  logic                  in_key_reuse;
`endif
  logic [DATA_WIDTH-1:0] input_vector;
  logic                  FF1_enable_comp;
  logic                  FF2_enable;
  logic                  rounds_MUX1;
  logic                  rounds_MUX2;
  logic [KEY_WIDTH-1:0]  round_key;
  logic [DATA_WIDTH-1:0] cipher_text;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_ciphertext;
  logic                  busy;

  modport slave (
    input  in_valid, in_plaintext, in_key,
`ifdef AES_KEY_REUSE_EN
           in_key_reuse,
`endif
           cipher_text, out_ready,
    output in_ready, input_vector, FF1_enable_comp, FF2_enable, rounds_MUX1, rounds_MUX2,
           round_key, out_valid, out_ciphertext, busy
  );

  modport master (
    output in_valid, in_plaintext, in_key,
`ifdef AES_KEY_REUSE_EN
           in_key_reuse,
`endif
           cipher_text, out_ready,
    input  in_ready, input_vector, FF1_enable_comp, FF2_enable, rounds_MUX1, rounds_MUX2,
           round_key, out_valid, out_ciphertext, busy
  );
endinterface

// File: rtl/aes_round_sequencer.sv
// Control and on-the-fly AES-128 key schedule for an external rounds datapath.
// Optional feature: define AES_KEY_REUSE_EN to let a transaction reuse the previous cipher key.
module aes_round_sequencer #(
  parameter int DATA_WIDTH = 128,
  parameter int KEY_WIDTH  = 128,
  parameter int NUM_ROUNDS = 10
) (
  input  logic                 clk,
  input  logic                 rst_n,
  aes_round_sequencer_if.slave bus
);
  typedef enum logic [2:0] {IDLE, LOAD, ROUND, FINAL, CAPTURE, DONE} state_t;

  state_t                state, state_next;
  logic [3:0]            rcnt;
  logic [7:0]            rcon;
  logic [KEY_WIDTH-1:0]  key_reg, key_next;
  logic [DATA_WIDTH-1:0] plain_reg, cipher_reg;
  logic [31:0]           rot_word, sub_word, w0, w1, w2, w3;
  logic                  advancing;
`ifdef AES_KEY_REUSE_EN
  logic [KEY_WIDTH-1:0]  prev_key;
`endif

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // S-box as GF(2^8) inverse (x^254, zero maps to zero) followed by the affine map.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] t;
    logic [7:0] inv;
    t   = x;
    inv = 8'h01;
    for (int i = 1; i < 8; i++) begin
      t   = gf_mul(t, t);
      inv = gf_mul(inv, t);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
               ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  always_comb begin
    sub_word = '0;
    rot_word = {key_reg[23:0], key_reg[31:24]};
    for (int i = 0; i < 4; i++) begin
      sub_word[8*i +: 8] = sbox(rot_word[8*i +: 8]);
    end
    w0       = key_reg[127:96] ^ sub_word ^ {rcon, 24'h000000};
    w1       = key_reg[95:64] ^ w0;
    w2       = key_reg[63:32] ^ w1;
    w3       = key_reg[31:0] ^ w2;
    key_next = {w0, w1, w2, w3};
  end

  // The key schedule stops at K10 so FINAL keeps presenting the last round key.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      rcnt       <= '0;
      rcon       <= '0;
      key_reg    <= '0;
      plain_reg  <= '0;
      cipher_reg <= '0;
`ifdef AES_KEY_REUSE_EN
      prev_key   <= '0;
`endif
    end else begin
      state <= state_next;
      case (state)
        IDLE: begin
          rcnt <= '0;
          if (bus.in_valid) begin
            plain_reg <= bus.in_plaintext;
            rcon      <= 8'h01;
`ifdef AES_KEY_REUSE_EN
            if (bus.in_key_reuse) begin
              key_reg <= prev_key;
            end else begin
              key_reg  <= bus.in_key;
              prev_key <= bus.in_key;
            end
`else
            key_reg <= bus.in_key;
`endif
          end
        end
        LOAD, ROUND: begin
          key_reg <= key_next;
          rcon    <= {rcon[6:0], 1'b0} ^ (rcon[7] ? 8'h1b : 8'h00);
          if (rcnt < 4'(NUM_ROUNDS)) rcnt <= rcnt + 4'd1;
        end
        CAPTURE: cipher_reg <= bus.cipher_text;
        default: ;
      endcase
    end
  end

  always_comb begin
    state_next = state;
    advancing  = 1'b0;
    case (state)
      IDLE:    if (bus.in_valid) state_next = LOAD;
      LOAD:    begin advancing = 1'b1; state_next = ROUND; end
      ROUND: begin
        advancing = 1'b1;
        if (rcnt == 4'(NUM_ROUNDS - 1)) state_next = FINAL;
      end
      FINAL:   begin advancing = 1'b1; state_next = CAPTURE; end
      CAPTURE: state_next = DONE;
      DONE:    if (bus.out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
    bus.in_ready        = rst_n && (state == IDLE);
    bus.busy            = (state != IDLE);
    bus.out_valid       = (state == DONE);
    bus.FF2_enable      = advancing;
    bus.FF1_enable_comp = !advancing;
    bus.rounds_MUX1     = (state == LOAD);
    bus.rounds_MUX2     = (state == FINAL);
    bus.round_key       = key_reg;
    bus.input_vector    = plain_reg;
    bus.out_ciphertext  = cipher_reg;
  end
endmodule
